// File: rtl/if_fetch_ctrl_pkg.sv
// if_fetch_ctrl_pkg: shared fetch-stage types and default constants.
package if_fetch_ctrl_pkg;
    localparam int FETCH_DATA_WIDTH = 32;
    localparam int FETCH_PC_SIZE = 13;
    localparam int RESET_PC_DEFAULT = 0;
    typedef struct packed {
        logic [FETCH_DATA_WIDTH-1:0] inst;
        logic [FETCH_PC_SIZE-1:0] pc;
    } fetch_entry_t;
endpackage

// File: rtl/if_fetch_ctrl_sync_fifo.sv
// sync_fifo: power-of-two synchronous FIFO with flush and occupancy count.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign do_pop = pop && count != '0;
    assign do_push = push && (count != (AW+1)'(DEPTH) || do_pop);
    assign rdata = mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: credit-limited PC sequencer and instruction buffer with redirect flush.
module if_fetch_ctrl import if_fetch_ctrl_pkg::*; #(
    parameter int DATA_WIDTH = FETCH_DATA_WIDTH,
    parameter int PC_SIZE = FETCH_PC_SIZE,
    parameter int RESET_PC = RESET_PC_DEFAULT,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  redirect_valid,
    input  logic [PC_SIZE-1:0]    redirect_pc,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [PC_SIZE-1:0]    imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [DATA_WIDTH-1:0] inst,
    output logic [PC_SIZE-1:0]    inst_pc
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int CW = LW + 4;
    logic rst_q;
    logic [PC_SIZE-1:0] fetch_pc, pcq_head;
    logic [CW-1:0] out_cnt, drop_cnt, out_next;
    logic [LW-1:0] fifo_cnt, pcq_cnt;
    logic [LW:0] occupancy;
    logic [DATA_WIDTH+PC_SIZE-1:0] head;
    logic accept, pop, rsp_drop, rsp_keep;
    // The PC queue only holds live (non-stale) requests, so its count is out_cnt - drop_cnt.
    assign pop = inst_valid && inst_ready;
    assign inst_valid = fifo_cnt != '0;
    assign occupancy = {1'b0, pcq_cnt} + {1'b0, fifo_cnt} - (LW+1)'(pop);
    assign imem_req_valid = !rst && !rst_q && !redirect_valid && occupancy < (LW+1)'(FIFO_DEPTH);
    assign imem_req_addr = fetch_pc;
    assign accept = imem_req_valid && imem_req_ready;
    assign rsp_drop = imem_rsp_valid && drop_cnt != '0;
    assign rsp_keep = imem_rsp_valid && drop_cnt == '0 && !redirect_valid;
    assign out_next = out_cnt + CW'(accept) - CW'(imem_rsp_valid);
    assign inst = inst_valid ? head[DATA_WIDTH+PC_SIZE-1:PC_SIZE] : '0;
    assign inst_pc = inst_valid ? head[PC_SIZE-1:0] : '0;
    sync_fifo #(.WIDTH(PC_SIZE), .DEPTH(FIFO_DEPTH)) u_pc_queue (
        .clk(clk), .rst(rst), .push(accept), .pop(rsp_keep), .flush(redirect_valid),
        .wdata(fetch_pc), .rdata(pcq_head), .count(pcq_cnt)
    );
    sync_fifo #(.WIDTH(DATA_WIDTH+PC_SIZE), .DEPTH(FIFO_DEPTH)) u_inst_fifo (
        .clk(clk), .rst(rst), .push(rsp_keep), .pop(pop), .flush(redirect_valid),
        .wdata({imem_rsp_data, pcq_head}), .rdata(head), .count(fifo_cnt)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            rst_q <= 1'b1;
            fetch_pc <= PC_SIZE'(RESET_PC);
            out_cnt <= '0;
            drop_cnt <= '0;
        end else begin
            rst_q <= 1'b0;
            out_cnt <= out_next;
            if (redirect_valid) begin
                fetch_pc <= redirect_pc & ~PC_SIZE'(3);
                drop_cnt <= out_next;
            end else begin
                if (accept) fetch_pc <= fetch_pc + PC_SIZE'(4);
                if (rsp_drop) drop_cnt <= drop_cnt - CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb_if_fetch_ctrl: directed scoreboard bench with a latency-configurable memory model.
module tb_if_fetch_ctrl;
    localparam int PW = 13;
    localparam int DW = 32;
    logic clk = 1'b0;
    logic rst, redirect_valid, imem_req_valid, imem_req_ready, imem_rsp_valid, inst_valid, inst_ready;
    logic [PW-1:0] redirect_pc, imem_req_addr, inst_pc;
    logic [DW-1:0] imem_rsp_data, inst;
    typedef struct { logic [PW-1:0] addr; int due; } req_t;
    req_t pend[$];
    req_t nreq;
    logic [PW-1:0] exp_pc_q[$];
    logic [PW-1:0] exp_addr, prev_addr, mon_e;
    int checks = 0, errors = 0, cyc = 0, lat = 1, acc_live = 0, pop_live = 0;
    bit rnd_ready = 1'b0, prev_wait = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    if_fetch_ctrl dut (
        .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc)
    );

    function automatic logic [DW-1:0] memf(input logic [PW-1:0] a);
        return {16'hC0DE, 3'b000, a};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_seq(input logic [PW-1:0] start, input int n);
        for (int i = 0; i < n; i++) exp_pc_q.push_back(start + PW'(4 * i));
    endtask

    task automatic do_reset(input int l, input bit r);
        rst = 1'b1;
        inst_ready = 1'b0;
        redirect_valid = 1'b0;
        lat = l;
        rnd_ready = r;
        tick();
        tick();
        exp_addr = '0;
        rst = 1'b0;
    endtask

    task automatic drain;
        for (int i = 0; i < 400 && exp_pc_q.size() != 0; i++) tick();
        chk("drain_remaining", 32'(exp_pc_q.size()), 32'd0);
        exp_pc_q.delete();
        inst_ready = 1'b0;
    endtask

    // scoreboard monitor: every decode handshake pops one expected entry
    initial forever begin
        @(negedge clk);
        if (!rst && inst_valid && inst_ready) begin
            if (exp_pc_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_inst actual_pc=%h required=none", inst_pc);
            end else begin
                mon_e = exp_pc_q.pop_front();
                chk("inst_pc", 32'(inst_pc), 32'(mon_e));
                chk("inst_data", inst, memf(mon_e));
            end
        end
    end

    // memory model plus request-side checks
    initial begin
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend.delete();
                prev_wait = 1'b0;
                acc_live = 0;
                pop_live = 0;
            end else begin
                if (prev_wait && imem_req_valid) chk("addr_stable", 32'(imem_req_addr), 32'(prev_addr));
                if (imem_req_valid && imem_req_ready) begin
                    chk("req_addr", 32'(imem_req_addr), 32'(exp_addr));
                    exp_addr = exp_addr + PW'(4);
                    nreq.addr = imem_req_addr;
                    nreq.due = cyc + lat;
                    pend.push_back(nreq);
                end
                prev_wait = imem_req_valid && !imem_req_ready;
                prev_addr = imem_req_addr;
                if (redirect_valid) begin
                    acc_live = 0;
                    pop_live = 0;
                end else begin
                    acc_live += int'(imem_req_valid && imem_req_ready);
                    pop_live += int'(inst_valid && inst_ready);
                    chk("occupancy_le_2", 32'(acc_live - pop_live <= 2), 32'd1);
                end
            end
            @(posedge clk);
            #1;
            imem_rsp_valid = 1'b0;
            if (!rst && pend.size() != 0 && pend[0].due <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data = memf(pend[0].addr);
                void'(pend.pop_front());
            end
            imem_req_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        inst_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        exp_addr = '0;
        tick();
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_inst_pc", 32'(inst_pc), 32'd0);
        // streaming from reset, latency 1
        do_reset(1, 1'b0);
        push_seq(13'h0000, 8);
        inst_ready = 1'b1;
        tick();
        chk("first_req_valid", 32'(imem_req_valid), 32'd1);
        chk("first_req_addr", 32'(imem_req_addr), 32'h0);
        tick();
        chk("first_inst_not_yet", 32'(inst_valid), 32'd0);
        tick();
        chk("first_inst_valid", 32'(inst_valid), 32'd1);
        chk("first_inst_pc", 32'(inst_pc), 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stream_valid", 32'(inst_valid), 32'd1);
        end
        drain();
        // decode stall for 5 cycles
        do_reset(1, 1'b0);
        push_seq(13'h0000, 10);
        inst_ready = 1'b1;
        repeat (4) tick();
        inst_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", 32'(inst_valid), 32'd1);
            chk("stall_pc", 32'(inst_pc), 32'h4);
            chk("stall_inst", inst, 32'hC0DE0004);
            tick();
        end
        inst_ready = 1'b1;
        drain();
        // latency 3 with random request ready
        do_reset(3, 1'b1);
        push_seq(13'h0000, 12);
        inst_ready = 1'b1;
        drain();
        // redirect to 0x104 with two requests outstanding
        do_reset(3, 1'b0);
        repeat (3) tick();
        redirect_valid = 1'b1;
        redirect_pc = 13'h0104;
        #1;
        chk("redir_req_blocked", 32'(imem_req_valid), 32'd0);
        tick();
        redirect_valid = 1'b0;
        exp_addr = 13'h0104;
        #1;
        chk("redir_inst_valid", 32'(inst_valid), 32'd0);
        chk("redir_req_valid", 32'(imem_req_valid), 32'd1);
        chk("redir_req_addr", 32'(imem_req_addr), 32'h104);
        exp_pc_q.push_back(13'h0104);
        exp_pc_q.push_back(13'h0108);
        exp_pc_q.push_back(13'h010C);
        inst_ready = 1'b1;
        drain();
        // redirect to 0x103 with a response and a decode handshake in the same cycle
        do_reset(1, 1'b0);
        exp_pc_q.push_back(13'h0000);
        exp_pc_q.push_back(13'h0004);
        exp_pc_q.push_back(13'h0008);
        exp_pc_q.push_back(13'h0100);
        exp_pc_q.push_back(13'h0104);
        exp_pc_q.push_back(13'h0108);
        inst_ready = 1'b1;
        repeat (5) tick();
        chk("hs_redir_valid", 32'(inst_valid), 32'd1);
        chk("hs_redir_pc", 32'(inst_pc), 32'h8);
        redirect_valid = 1'b1;
        redirect_pc = 13'h0103;
        tick();
        redirect_valid = 1'b0;
        exp_addr = 13'h0100;
        #1;
        chk("hs_flush_valid", 32'(inst_valid), 32'd0);
        chk("hs_req_addr", 32'(imem_req_addr), 32'h100);
        drain();
        // address wrap at the top of the PC space
        do_reset(1, 1'b0);
        redirect_valid = 1'b1;
        redirect_pc = 13'h1FFC;
        tick();
        redirect_valid = 1'b0;
        exp_addr = 13'h1FFC;
        #1;
        chk("wrap_first_addr", 32'(imem_req_addr), 32'h1FFC);
        exp_pc_q.push_back(13'h1FFC);
        exp_pc_q.push_back(13'h0000);
        exp_pc_q.push_back(13'h0004);
        inst_ready = 1'b1;
        tick();
        chk("wrap_next_addr", 32'(imem_req_addr), 32'h0);
        drain();
        // reset mid-stream
        do_reset(1, 1'b0);
        push_seq(13'h0000, 2);
        inst_ready = 1'b1;
        repeat (4) tick();
        tick();
        rst = 1'b1;
        inst_ready = 1'b0;
        #1;
        chk("midrst_req_valid", 32'(imem_req_valid), 32'd0);
        tick();
        chk("midrst_inst_valid", 32'(inst_valid), 32'd0);
        chk("midrst_inst", inst, 32'd0);
        chk("midrst_inst_pc", 32'(inst_pc), 32'd0);
        chk("midrst_req_valid2", 32'(imem_req_valid), 32'd0);
        chk("midrst_pops", 32'(exp_pc_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
